seq_detect_prog: RTL and testbench

Parametrised serial bit-sequence detector with a programmable pattern of PAT_W bits, selectable overlapping or non-overlapping matching, and a saturating match counter. It is the successor to the fixed three-state "101" Mealy detector. It consumes a qualified serial bit stream (in_valid/in_bit) and flags each occurrence of the loaded pattern. It sits between a serial front end and status/interrupt logic.

---
 rtl/seq_detect_pkg.sv | 10 +
 rtl/seq_detect_prog_sat_counter.sv | 17 +
 rtl/seq_detect_prog.sv | 65 ++++++
 tb/tb_seq_detect_prog.sv | 119 +++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared constants and fill helper for the programmable sequence detector.
package seq_detect_pkg;
  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;
  localparam int DEF_PAT_W = 3;
  localparam int DEF_CNT_W = 8;
  function automatic logic [5:0] fill_next(input logic [5:0] fill, input logic [5:0] full);
    return (fill < full) ? fill + 6'd1 : full;
  endfunction
endpackage

// File: rtl/seq_detect_prog_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial pattern detector with overlap control and saturating match count.
// Define SEQ_DETECT_MATCH_REG_EN to register match (one cycle later, aligned with match_count).
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter int               CNT_W   = DEF_CNT_W,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(3'b101)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             match,
  output logic             armed,
  output logic [CNT_W-1:0] match_count
);
  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0] FULL = FW'(PAT_W - 1);
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d, win;
  logic             step, match_c;
  always_comb begin
    win     = {hist_q, in_bit};
    step    = in_valid & ~cfg_load;
    match_c = step & (fill_q == FULL) & (win == pat_q);
    pat_d   = cfg_load ? pattern : pat_q;
    hist_d  = cfg_load ? '0 : step ? win[PAT_W-2:0] : hist_q;
    // a non-overlapping match restarts the fill so its bits cannot seed the next match
    fill_d  = cfg_load ? '0 : !step ? fill_q :
              (match_c && overlap_en == OVL_OFF) ? '0 : FW'(fill_next(6'(fill_q), 6'(FULL)));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PAT_RST;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
    end
  assign armed = (fill_q == FULL);
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (match_c),
    .clr  (cnt_clr | cfg_load),
    .count(match_count)
  );
`ifdef SEQ_DETECT_MATCH_REG_EN
  logic match_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) match_q <= 1'b0;
    else match_q <= match_c;
  assign match = match_q;
`else
  assign match = match_c;
`endif
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: directed vectors with a queued scoreboard checked by an independent monitor.
module tb_seq_detect_prog;
  logic       clk = 0, rst_n = 0;
  logic       in_valid = 0, in_bit = 0, cfg_load = 0, overlap_en = 1, cnt_clr = 0;
  logic [2:0] pattern = 3'b101;
  logic       match, armed;
  logic [1:0] match_count;
  int checks = 0, failures = 0;
  typedef struct packed {logic m; logic a; logic [1:0] c;} exp_t;
  exp_t q[$];

  seq_detect_prog #(.PAT_W(3), .CNT_W(2), .PAT_RST(3'b101)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
    .pattern(pattern), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .match(match), .armed(armed), .match_count(match_count)
  );

  always #5 clk = ~clk;

  function void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("match", match, e.m);
      chk("armed", armed, e.a);
      chk("count", match_count, e.c);
    end
  end

  task automatic cyc(input logic v, b, ld, input logic [2:0] p, input logic ovl, clr,
                     input logic em, ea, input logic [1:0] ec);
    @(posedge clk);
    #1;
    in_valid = v; in_bit = b; cfg_load = ld; pattern = p; overlap_en = ovl; cnt_clr = clr;
    q.push_back('{m: em, a: ea, c: ec});
  endtask

  initial begin
    #12 rst_n = 1;
    cyc(0,0,0,3'b101,1,0, 0,0,0);
    // overlapping 1,0,1,0,1
    cyc(1,1,0,3'b101,1,0, 0,0,0);
    cyc(1,0,0,3'b101,1,0, 0,0,0);
    cyc(1,1,0,3'b101,1,0, 1,1,0);
    cyc(1,0,0,3'b101,1,0, 0,1,1);
    cyc(1,1,0,3'b101,1,0, 1,1,1);
    cyc(0,0,0,3'b101,1,0, 0,1,2);
    cyc(0,0,1,3'b101,1,0, 0,1,2);
    // non-overlapping: second 101 shares a bit, so no match
    cyc(1,1,0,3'b101,0,0, 0,0,0);
    cyc(1,0,0,3'b101,0,0, 0,0,0);
    cyc(1,1,0,3'b101,0,0, 1,1,0);
    cyc(1,0,0,3'b101,0,0, 0,0,1);
    cyc(1,1,0,3'b101,0,0, 0,0,1);
    cyc(0,0,0,3'b101,0,0, 0,1,1);
    cyc(0,0,1,3'b101,1,0, 0,1,1);
    // idle gaps ignored even with in_bit toggling
    cyc(1,1,0,3'b101,1,0, 0,0,0);
    cyc(0,1,0,3'b101,1,0, 0,0,0);
    cyc(0,0,0,3'b101,1,0, 0,0,0);
    cyc(0,1,0,3'b101,1,0, 0,0,0);
    cyc(1,0,0,3'b101,1,0, 0,0,0);
    cyc(0,1,0,3'b101,1,0, 0,1,0);
    cyc(1,1,0,3'b101,1,0, 1,1,0);
    cyc(0,0,0,3'b101,1,0, 0,1,1);
    // cfg_load discards the coincident bit and swaps the pattern
    cyc(0,0,1,3'b101,1,0, 0,1,1);
    cyc(1,1,0,3'b101,1,0, 0,0,0);
    cyc(1,0,0,3'b101,1,0, 0,0,0);
    cyc(1,1,1,3'b110,1,0, 0,1,0);
    cyc(1,1,0,3'b110,1,0, 0,0,0);
    cyc(1,1,0,3'b110,1,0, 0,0,0);
    cyc(1,0,0,3'b110,1,0, 1,1,0);
    cyc(0,0,0,3'b110,1,0, 0,1,1);
    // saturation at 3 over seven overlapping matches
    cyc(0,0,1,3'b101,1,0, 0,1,1);
    cyc(1,1,0,3'b101,1,0, 0,0,0);
    cyc(1,0,0,3'b101,1,0, 0,0,0);
    for (int k = 1; k <= 7; k++) begin
      cyc(1,1,0,3'b101,1,0, 1,1, 2'((k-1) > 3 ? 3 : k-1));
      if (k < 7) cyc(1,0,0,3'b101,1,0, 0,1, 2'(k > 3 ? 3 : k));
    end
    cyc(0,0,0,3'b101,1,0, 0,1,3);
    // clear wins over a coincident match
    cyc(1,0,0,3'b101,1,0, 0,1,3);
    cyc(1,1,0,3'b101,1,1, 1,1,3);
    cyc(0,0,0,3'b101,1,0, 0,1,0);
    cyc(1,0,0,3'b101,1,0, 0,1,0);
    cyc(1,1,0,3'b101,1,0, 1,1,0);
    cyc(1,1,0,3'b101,1,0, 0,1,1);
    cyc(1,0,0,3'b101,1,0, 0,1,1);
    cyc(0,0,0,3'b101,1,0, 0,1,1);
    // asynchronous reset mid-cycle wipes the partial 1,0
    @(posedge clk);
    #2 rst_n = 0;
    #4 rst_n = 1;
    cyc(1,1,0,3'b101,1,0, 0,0,0);
    cyc(1,0,0,3'b101,1,0, 0,0,0);
    cyc(0,0,0,3'b101,1,0, 0,1,0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
